sprite_fetch_scheduler: RTL and testbench
=========================================

// Module: sprite_fetch_scheduler
// PURPOSE
//  Shares one single-port sprite ROM between two on-screen characters.
//  - During each horizontal blank it prefetches the next scanline's 16-pixel row of each character into line buffers.
//  - During active video it serves per-pixel RGB and coverage to the colour mapper.
//  - Replaces per-character ROM ports; sits between the VGA timing and the colour mapper.
// PARAMETERS
//  ROM_LAT      1          ROM read latency in cycles, rom_rd to rom_data valid (1..3)
//  TRANSP_KEY   24'hFF00FF RGB value treated as transparent (only when TRANSPARENCY_EN is defined)
// PORTS
//  Clk         in   1     system clock
//  Reset_n     in   1     asynchronous active-low reset
//  line_start  in   1     1-cycle pulse at start of horizontal blank
//  next_y      in   10    scanline to prefetch; sampled on line_start
//  SpriteX0/1  in   10    character top-left X; sampled on line_start
//  SpriteY0/1  in   10    character top-left Y; sampled on line_start
//  FrameSel0/1 in   4     animation frame; selects a 256-word ROM page; sampled on line_start
//  rom_rd      out  1     ROM read strobe
//  rom_addr    out  12    {frame[3:0], row[3:0], col[3:0]}
//  rom_data    in   24    ROM RGB; valid ROM_LAT cycles after rom_rd
//  de          in   1     display enable (active video)
//  DrawX       in   10    current pixel X
//  pix_rgb     out  24    selected character pixel; 0 when pix_valid=0
//  pix_valid   out  1     an opaque character pixel covers DrawX
//  sprite_hit  out  2     raw per-character coverage of DrawX, independent of transparency
//  busy        out  1     fetch FSM not IDLE
//  overrun     out  1     1-cycle pulse: de rose while busy
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//   - state=IDLE; all outputs 0; row_ok[1:0]=0 in both banks; line-buffer data don't-care.
//  FSM states: IDLE, CHK0, FET0, DRN0, CHK1, FET1, DRN1, SWAP.
//   - IDLE -line_start-> CHK0. Latches next_y, SpriteX/Y, FrameSel.
//   - CHKn: row = next_y - SpriteYn (10-bit wrap).
//     row < 16 -> FETn, row_ok[n]=1 in shadow bank.
//     Otherwise row_ok[n]=0 and go to CHK(n+1), or SWAP after sprite 1.
//   - FETn: 16 consecutive cycles, rom_rd=1, col 0..15, rom_addr={FrameSeln,row[3:0],col}.
//   - DRNn: ROM_LAT cycles. Returned words are written to shadow[n][col] in issue order.
//   - SWAP: shadow bank becomes active (bank select toggles). Latched SpriteX becomes the display X. Next state IDLE.
//   - Both sprites hit: line_start to IDLE = 2*(17+ROM_LAT)+2 cycles.
//  Simultaneous events:
//   - line_start while busy: abort, restart at CHK0 with new samples; active bank untouched.
//   - de rising edge while busy: overrun=1 for 1 cycle; abort to IDLE.
//     No swap, and active row_ok cleared, so no characters are drawn this line.
//   - line_start and de rising edge in the same cycle: line_start wins, no overrun.
//  Display path (registered, 1-cycle latency from DrawX/de to outputs):
//   - offn = DrawX - displayXn (10-bit wrap).
//   - hitn = de & active row_ok[n] & offn < 16.
//   - sprite_hit = {hit1, hit0}.
//   - Sprite 0 has priority over sprite 1. pix_rgb = winner's active[n][offn[3:0]].
//   - de=0: pix_valid=0, sprite_hit=0, pix_rgb=0.
//  Read and write banks are always distinct; a display read never observes a partially filled row.
// CONFIGURATION
//  TRANSPARENCY_EN
//   - Defined: a pixel equal to TRANSP_KEY is not opaque.
//     If sprite 0's pixel is transparent, sprite 1 (if hit and opaque) is shown.
//     If none is opaque, pix_valid=0 and pix_rgb=0.
//   - Undefined: every covered pixel is opaque (pure 16x16 box), and pix_valid = hit0|hit1.
// STRUCTURE
//  Package sprite_pkg:
//   - SPR_W=16, SPR_H=16; typedef logic [23:0] rgb_t.
//   - typedef enum fetch_state_t (the FSM states above); TRANSP_KEY_DEF.
//  Sub-module sprite_line_buf: 16 x rgb_t register row, 1 write port and 1 async read port.
//   - Four instances: 2 sprites x 2 banks.
//  ROM_LAT-deep valid/col shift register inside this module; no other sub-modules.
// TESTING
//  1 Reset with Reset_n=0 mid-FET0 -> busy=0 and rom_rd=0 the same cycle.
//    All outputs stay 0 until the next line_start.
//  2 next_y=100, SpriteY0=95, SpriteY1=200 -> 16 reads, addrs {F0,4'd5,0..15}.
//    Sprite 1 is skipped; busy clears after 2+17+ROM_LAT+1 cycles.
//  3 SpriteX0=300, SpriteX1=308, both rows hit, de=1, DrawX=300..323:
//    - DrawX 300..315: pix shows sprite 0.
//    - DrawX 316..323: pix shows sprite 1.
//    - sprite_hit=2'b11 for DrawX 308..315; outputs lag DrawX by 1 cycle.
//  4 SpriteY0=1020, next_y=2 -> row 6 (wrap) fetched; SpriteX0=1020, DrawX=3 -> hit at offset 7.
//  5 de raised 10 cycles after line_start -> overrun pulse of 1 cycle; pix_valid=0 for the whole line.
//    The next line recovers normally.
//  6 TRANSPARENCY_EN, sprite0 pixel=24'hFF00FF over sprite1 pixel=24'h123456 -> pix_rgb=24'h123456.
//    The same stimulus with the macro undefined -> pix_rgb=24'hFF00FF.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch scheduler.
package sprite_pkg;

  localparam int SPR_W = 16;
  localparam int SPR_H = 16;

  typedef logic [23:0] rgb_t;

  typedef enum logic [2:0] {
    IDLE,
    CHK0,
    FET0,
    DRN0,
    CHK1,
    FET1,
    DRN1,
    SWAP
  } fetch_state_t;

  // Magenta is the colour key used by the sprite art.
  localparam rgb_t TRANSP_KEY_DEF = 24'hFF00FF;

endpackage

// File: rtl/sprite_line_buf.sv
// One 16-pixel sprite row: a synchronous write port and an async read port.
// No reset: contents are only trusted once the matching row_ok bit is set.
module sprite_line_buf
  import sprite_pkg::*;
(
  input  logic        Clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [23:0] wdata,
  input  logic [3:0]  raddr,
  output logic [23:0] rdata
);

  rgb_t mem [SPR_W];

  // Write one pixel per cycle as ROM words return.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Shares a single-port sprite ROM between two characters. Each horizontal blank
// prefetches the next scanline's row of both characters into a shadow bank of
// line buffers, which is swapped in once both rows are complete. During active
// video the active bank is read per pixel to produce RGB and coverage.
// Optional build macro: TRANSPARENCY_EN makes pixels equal to TRANSP_KEY see-through.
module sprite_fetch_scheduler
  import sprite_pkg::*;
#(
  parameter int ROM_LAT = 1
`ifdef TRANSPARENCY_EN
  ,
  parameter logic [23:0] TRANSP_KEY = TRANSP_KEY_DEF
`endif
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        line_start,
  input  logic [9:0]  next_y,
  input  logic [9:0]  SpriteX0,
  input  logic [9:0]  SpriteX1,
  input  logic [9:0]  SpriteY0,
  input  logic [9:0]  SpriteY1,
  input  logic [3:0]  FrameSel0,
  input  logic [3:0]  FrameSel1,
  output logic        rom_rd,
  output logic [11:0] rom_addr,
  input  logic [23:0] rom_data,
  input  logic        de,
  input  logic [9:0]  DrawX,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  output logic [1:0]  sprite_hit,
  output logic        busy,
  output logic        overrun
);

  fetch_state_t state, state_nxt;

  logic [3:0]       cnt;          // column during FETn, drain count during DRNn
  logic [9:0]       lat_y;
  logic [1:0][9:0]  lat_x, lat_sy, disp_x;
  logic [1:0][3:0]  lat_f;
  logic [1:0][1:0]  row_ok;       // [bank][sprite]
  logic             bank_sel;     // active (display) bank
  logic             shadow_bank;
  logic             de_q;

  logic             cur_spr;
  logic [9:0]       row;
  logic             row_hit;
  logic             chk_st;
  logic             abort_ovr;
  logic             flush;
  logic             swap_en;

  // ROM return tracking: stage k holds the read issued k cycles ago.
  logic [ROM_LAT:1]      vld_pipe;
  logic [ROM_LAT:1]      spr_pipe;
  logic [ROM_LAT:1][3:0] col_pipe;
  logic                  wr_en;
  logic                  wr_spr;
  logic [3:0]            wr_col;

  logic [1:0][1:0][23:0] lb_rd;   // [bank][sprite]
  logic [1:0][9:0]       off;
  logic [1:0]            hit;
  logic [1:0]            opaque;
  logic [1:0][23:0]      pix;

  // Fetch-side combinational terms shared by next-state and output logic.
  always_comb begin
    cur_spr     = (state == CHK1) || (state == FET1) || (state == DRN1);
    row         = lat_y - lat_sy[cur_spr];
    row_hit     = (row < 10'(SPR_H));
    chk_st      = (state == CHK0) || (state == CHK1);
    shadow_bank = ~bank_sel;
    // line_start beats a simultaneous de rise, so no overrun in that case.
    abort_ovr   = (state != IDLE) && de && !de_q && !line_start;
    flush       = line_start || abort_ovr;
    swap_en     = (state == SWAP) && !flush;
  end

  // Fetch state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: restarts and aborts override the normal sequence.
  always_comb begin
    state_nxt = state;
    if (line_start) begin
      state_nxt = CHK0;
    end else if (abort_ovr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = IDLE;
        CHK0: state_nxt = row_hit ? FET0 : CHK1;
        FET0: if (cnt == 4'd15) state_nxt = DRN0;
        DRN0: if (cnt == 4'(ROM_LAT - 1)) state_nxt = CHK1;
        CHK1: state_nxt = row_hit ? FET1 : SWAP;
        FET1: if (cnt == 4'd15) state_nxt = DRN1;
        DRN1: if (cnt == 4'(ROM_LAT - 1)) state_nxt = SWAP;
        SWAP: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Fetch outputs; address is held at zero when no read is issued.
  always_comb begin
    busy     = (state != IDLE);
    rom_rd   = (state == FET0) || (state == FET1);
    rom_addr = '0;
    if (rom_rd) rom_addr = {lat_f[cur_spr], row[3:0], cnt};
  end

  // Per-state cycle counter, cleared whenever the state changes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else                         cnt <= cnt + 4'd1;
  end

  // Line parameters, bank bookkeeping and the overrun pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lat_y    <= '0;
      lat_x    <= '0;
      lat_sy   <= '0;
      lat_f    <= '0;
      disp_x   <= '0;
      row_ok   <= '0;
      bank_sel <= 1'b0;
      de_q     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      de_q    <= de;
      overrun <= abort_ovr;
      if (line_start) begin
        lat_y  <= next_y;
        lat_x  <= {SpriteX1, SpriteX0};
        lat_sy <= {SpriteY1, SpriteY0};
        lat_f  <= {FrameSel1, FrameSel0};
      end
      if (chk_st) row_ok[shadow_bank][cur_spr] <= row_hit;
      if (swap_en) begin
        bank_sel <= ~bank_sel;
        disp_x   <= lat_x;
      end
      // Blank the whole line: the shown bank belongs to the previous scanline.
      if (abort_ovr) row_ok[bank_sel] <= 2'b00;
    end
  end

  // Read-valid shift register; aborted reads are dropped in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rom_rd && !flush;
      for (int k = 2; k <= ROM_LAT; k++) vld_pipe[k] <= vld_pipe[k-1] && !flush;
    end
  end

  // Sprite/column tags travelling alongside the valid bits.
  always_ff @(posedge Clk) begin
    spr_pipe[1] <= cur_spr;
    col_pipe[1] <= cnt;
    for (int k = 2; k <= ROM_LAT; k++) begin
      spr_pipe[k] <= spr_pipe[k-1];
      col_pipe[k] <= col_pipe[k-1];
    end
  end

  assign wr_en  = vld_pipe[ROM_LAT];
  assign wr_spr = spr_pipe[ROM_LAT];
  assign wr_col = col_pipe[ROM_LAT];

  // Line buffers: instance i serves bank i/2, sprite i%2. Writes only ever
  // target the shadow bank; the display only ever reads the active bank.
  for (genvar i = 0; i < 4; i++) begin : g_lb
    localparam int B = i / 2;
    localparam int S = i % 2;
    sprite_line_buf u_lb (
      .Clk   (Clk),
      .we    (wr_en && (wr_spr == 1'(S)) && (shadow_bank == 1'(B))),
      .waddr (wr_col),
      .wdata (rom_data),
      .raddr (off[S][3:0]),
      .rdata (lb_rd[B][S])
    );
  end

  // Display coverage and opacity for the current DrawX.
  always_comb begin
    off    = '0;
    hit    = '0;
    opaque = '0;
    pix    = '0;
    for (int n = 0; n < 2; n++) begin
      off[n] = DrawX - disp_x[n];
      hit[n] = de && row_ok[bank_sel][n] && (off[n] < 10'(SPR_W)) && !abort_ovr;
      pix[n] = lb_rd[bank_sel][n];
`ifdef TRANSPARENCY_EN
      opaque[n] = hit[n] && (pix[n] != TRANSP_KEY);
`else
      opaque[n] = hit[n];
`endif
    end
  end

  // Registered pixel outputs; sprite 0 wins when both are opaque.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_rgb    <= '0;
      pix_valid  <= 1'b0;
      sprite_hit <= '0;
    end else begin
      if (opaque[0])      pix_rgb <= pix[0];
      else if (opaque[1]) pix_rgb <= pix[1];
      else                pix_rgb <= '0;
      pix_valid  <= |opaque;
      sprite_hit <= hit;
    end
  end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Directed bench for sprite_fetch_scheduler with a latency-accurate ROM model.
module tb_sprite_fetch_scheduler;

  localparam int ROM_LAT = 1;

  logic        Clk, Reset_n, line_start, de;
  logic [9:0]  next_y, SpriteX0, SpriteX1, SpriteY0, SpriteY1, DrawX;
  logic [3:0]  FrameSel0, FrameSel1;
  logic        rom_rd, pix_valid, busy, overrun;
  logic [11:0] rom_addr;
  logic [23:0] rom_data, pix_rgb;
  logic [1:0]  sprite_hit;

  sprite_fetch_scheduler #(.ROM_LAT(ROM_LAT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .next_y(next_y),
    .SpriteX0(SpriteX0), .SpriteX1(SpriteX1), .SpriteY0(SpriteY0), .SpriteY1(SpriteY1),
    .FrameSel0(FrameSel0), .FrameSel1(FrameSel1), .rom_rd(rom_rd), .rom_addr(rom_addr),
    .rom_data(rom_data), .de(de), .DrawX(DrawX), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .sprite_hit(sprite_hit), .busy(busy), .overrun(overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM: word valid ROM_LAT cycles after the read is presented.
  logic [23:0] rom_mem [4096];
  logic [23:0] rq [ROM_LAT];
  always @(posedge Clk) begin
    rq[0] <= rom_mem[rom_addr];
    for (int k = 1; k < ROM_LAT; k++) rq[k] <= rq[k-1];
  end
  assign rom_data = rq[ROM_LAT-1];

  int n_chk = 0, n_pass = 0;

  // Expected active-bank contents: X position, ROM row base and row-valid.
  logic [9:0]  ax0, ax1;
  logic [11:0] ab0, ab1;
  logic        aok0 = 1'b0, aok1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Launch one line fetch, check addresses against the expected sequence,
  // and report the cycle (line_start cycle = 0) on which busy dropped.
  task automatic run_line(input logic [9:0] ny, y0, y1, x0, x1, input logic [3:0] f0, f1,
                          output int idle_k, output int nrd, output int aerr);
    logic [9:0]  r0, r1;
    logic [11:0] expq[$];
    r0 = ny - y0;
    r1 = ny - y1;
    if (r0 < 16) for (int c = 0; c < 16; c++) expq.push_back({f0, r0[3:0], 4'(c)});
    if (r1 < 16) for (int c = 0; c < 16; c++) expq.push_back({f1, r1[3:0], 4'(c)});
    next_y = ny; SpriteY0 = y0; SpriteY1 = y1; SpriteX0 = x0; SpriteX1 = x1;
    FrameSel0 = f0; FrameSel1 = f1;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    idle_k = -1; nrd = 0; aerr = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge Clk);
      if (rom_rd) begin
        nrd++;
        if (expq.size() == 0) aerr++;
        else begin
          if (rom_addr !== expq[0]) aerr++;
          void'(expq.pop_front());
        end
      end
      if (!busy) begin idle_k = k; break; end
      @(posedge Clk); #1;
    end
    aerr += expq.size();
    tick();
    if (idle_k > 0) begin
      ax0 = x0; ax1 = x1;
      ab0 = {f0, r0[3:0], 4'h0}; ab1 = {f1, r1[3:0], 4'h0};
      aok0 = (r0 < 16); aok1 = (r1 < 16);
    end
  endtask

  // Present one pixel and compare the registered outputs a cycle later.
  task automatic check_pix(input logic [9:0] x, input string tag);
    logic [9:0]  o0, o1;
    logic        h0, h1, v0, v1;
    logic [23:0] p0, p1, ep;
    de = 1'b1; DrawX = x;
    tick();
    o0 = x - ax0; o1 = x - ax1;
    h0 = aok0 && (o0 < 16); h1 = aok1 && (o1 < 16);
    p0 = rom_mem[{ab0[11:4], o0[3:0]}];
    p1 = rom_mem[{ab1[11:4], o1[3:0]}];
`ifdef TRANSPARENCY_EN
    v0 = h0 && (p0 != 24'hFF00FF); v1 = h1 && (p1 != 24'hFF00FF);
`else
    v0 = h0; v1 = h1;
`endif
    ep = v0 ? p0 : (v1 ? p1 : 24'h0);
    chk({tag, "_hit"}, 32'(sprite_hit), 32'({h1, h0}));
    chk({tag, "_vld"}, 32'(pix_valid), 32'(v0 | v1));
    chk({tag, "_rgb"}, 32'(pix_rgb), 32'(ep));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_k, nrd, aerr, bad, k;
    for (int a = 0; a < 4096; a++) rom_mem[a] = {12'hA5C, 12'(a)};
    rom_mem[12'h703] = 24'hFF00FF;
    rom_mem[12'h803] = 24'h123456;
    rom_mem[12'h704] = 24'hFF00FF;
    rom_mem[12'h804] = 24'hFF00FF;

    Reset_n = 1'b0; line_start = 1'b0; de = 1'b0; DrawX = '0;
    next_y = '0; SpriteX0 = '0; SpriteX1 = '0; SpriteY0 = '0; SpriteY1 = '0;
    FrameSel0 = '0; FrameSel1 = '0;
    #22;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(rom_rd), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_outs", 32'({pix_rgb, pix_valid, sprite_hit, overrun}), 0);
    #1 Reset_n = 1'b1;
    tick();

    // Sprite 0 row 5 only; sprite 1 far below.
    run_line(10'd100, 10'd95, 10'd200, 10'd50, 10'd600, 4'd3, 4'd9, idle_k, nrd, aerr);
    chk("t2_nrd", nrd, 16);
    chk("t2_addr", aerr, 0);
    chk("t2_idle", idle_k, 20 + ROM_LAT);

    // Both rows hit, sprites 8 pixels apart.
    run_line(10'd50, 10'd40, 10'd45, 10'd300, 10'd308, 4'd1, 4'd2, idle_k, nrd, aerr);
    chk("t3_nrd", nrd, 32);
    chk("t3_addr", aerr, 0);
    chk("t3_idle", idle_k, 2 * (17 + ROM_LAT) + 2);
    for (int x = 298; x <= 325; x++) begin
      check_pix(10'(x), "t3");
      if (x == 300) chk("t3_first", 32'(pix_rgb), 32'h00A5C1A0);
      if (x == 315) chk("t3_last0", 32'(pix_rgb), 32'h00A5C1AF);
      if (x == 316) chk("t3_first1", 32'(pix_rgb), 32'h00A5C258);
      if (x == 310) chk("t3_both", 32'(sprite_hit), 32'h3);
    end
    de = 1'b0;
    tick();
    chk("t3_de0", 32'({pix_rgb, pix_valid, sprite_hit}), 0);

    // Reset lands mid-FET0 of a new line.
    next_y = 10'd50; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (4) tick();
    chk("t1_pre_rd", 32'(rom_rd), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 0);
    chk("t1_rd", 32'(rom_rd), 0);
    @(posedge Clk); #2 Reset_n = 1'b1;
    tick();
    aok0 = 1'b0; aok1 = 1'b0;
    bad = 0;
    for (int x = 300; x <= 323; x++) begin
      de = 1'b1; DrawX = 10'(x);
      tick();
      if ({pix_rgb, pix_valid, sprite_hit, overrun, busy, rom_rd, rom_addr} != 0) bad++;
    end
    chk("t1_quiet", bad, 0);
    de = 1'b0;
    tick();

    // Vertical and horizontal wrap.
    run_line(10'd2, 10'd1020, 10'd500, 10'd1020, 10'd600, 4'd5, 4'd9, idle_k, nrd, aerr);
    chk("t4_nrd", nrd, 16);
    chk("t4_addr", aerr, 0);
    chk("t4_idle", idle_k, 20 + ROM_LAT);
    check_pix(10'd1019, "t4_m1");
    check_pix(10'd1020, "t4_o0");
    check_pix(10'd3, "t4_o7");
    chk("t4_o7_rgb", 32'(pix_rgb), 32'h00A5C567);
    check_pix(10'd11, "t4_o15");
    check_pix(10'd12, "t4_o16");
    de = 1'b0;
    tick();

    // de rises 10 cycles into a fetch: overrun, line blanked.
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (9) tick();
    de = 1'b1; DrawX = 10'd1018;
    tick();
    chk("t5_ovr", 32'(overrun), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_vld", 32'({pix_valid, sprite_hit}), 0);
    aok0 = 1'b0; aok1 = 1'b0;
    check_pix(10'd1019, "t5_a");
    chk("t5_ovr_end", 32'(overrun), 0);
    bad = 0;
    for (int x = 1020; x <= 1039; x++) begin
      DrawX = 10'(x);
      tick();
      if (pix_valid || overrun) bad++;
    end
    chk("t5_blank", bad, 0);
    de = 1'b0;
    tick();
    run_line(10'd2, 10'd1020, 10'd500, 10'd1020, 10'd600, 4'd5, 4'd9, idle_k, nrd, aerr);
    chk("t5_rec_idle", idle_k, 20 + ROM_LAT);
    check_pix(10'd3, "t5_rec");
    de = 1'b0;
    tick();

    // line_start and de rise together mid-fetch: restart, no overrun.
    next_y = 10'd10; SpriteY0 = 10'd10; SpriteY1 = 10'd10;
    SpriteX0 = 10'd100; SpriteX1 = 10'd100; FrameSel0 = 4'd7; FrameSel1 = 4'd8;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    line_start = 1'b1; de = 1'b1; DrawX = 10'd900;
    tick();
    line_start = 1'b0;
    chk("sim_ovr", 32'(overrun), 0);
    chk("sim_busy", 32'(busy), 1);
    k = 1;
    while (busy && k < 200) begin tick(); k++; end
    chk("sim_idle", k, 2 * (17 + ROM_LAT) + 2);
    ax0 = 10'd100; ax1 = 10'd100; ab0 = 12'h700; ab1 = 12'h800;
    aok0 = 1'b1; aok1 = 1'b1;

    // Transparent sprite 0 pixel over sprite 1.
    check_pix(10'd102, "t6_op");
    check_pix(10'd103, "t6_key");
`ifdef TRANSPARENCY_EN
    chk("t6_rgb", 32'(pix_rgb), 32'h00123456);
`else
    chk("t6_rgb", 32'(pix_rgb), 32'h00FF00FF);
`endif
    check_pix(10'd104, "t6_both_key");
    de = 1'b0;
    tick();
    chk("t6_de0", 32'({pix_rgb, pix_valid, sprite_hit}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
